i2s_tx: RTL



---
 rtl/i2s_tx_if.sv | 16 +
 rtl/i2s_tx.sv | 112 +++++++++++
 2 files changed

// File: rtl/i2s_tx_if.sv
`default_nettype none
// ============================================================================
// Module   : i2s_tx_if
// Purpose  : Stereo sample valid/ready handshake from the equalizer output.
// Revision : 1.0
// ============================================================================
interface i2s_tx_if;
    logic signed [15:0] lft_smp;
    logic signed [15:0] rht_smp;
    logic               smp_vld;
    logic               smp_rdy;

    modport master (output lft_smp, output rht_smp, output smp_vld, input  smp_rdy);
    modport slave  (input  lft_smp, input  rht_smp, input  smp_vld, output smp_rdy);
endinterface
`default_nettype wire

// File: rtl/i2s_tx.sv
`default_nettype none
// ============================================================================
// Module   : i2s_tx
// Purpose  : I2S transmitter for the CS4272 (MCLK=clk/8, SCLK=clk/32,
//            LRCLK=clk/2048, 24-bit I2S words). Optional build macro
//            I2S_TX_UNDERFLOW_MUTE_EN sends silence instead of repeating.
// Revision : 1.0
// ============================================================================
module i2s_tx (
    input  logic     clk,
    input  logic     rst_n,
    i2s_tx_if.slave  smp_if,
    output logic     MCLK,
    output logic     SCLK,
    output logic     LRCLK,
    output logic     SDin,
    output logic     undrflw
);

    localparam logic [10:0] C_XFER_CNT = 11'h7FF;
    localparam logic [4:0]  C_FALL_PH  = 5'h1F;

    logic [10:0] cnt_q,       cnt_d;
    logic        hold_full_q, hold_full_d;
    logic [15:0] hold_l_q,    hold_l_d;
    logic [15:0] hold_r_q,    hold_r_d;
    logic [15:0] frm_l_q,     frm_l_d;
    logic [15:0] frm_r_q,     frm_r_d;
    logic [23:0] shift_q,     shift_d;
    logic        undrflw_q,   undrflw_d;

    logic w_xfer;
    logic w_accept;
    logic w_fall;
    logic w_load;

    assign w_xfer   = (cnt_q == C_XFER_CNT);
    assign w_accept = smp_if.smp_vld & ~hold_full_q;
    assign w_fall   = (cnt_q[4:0] == C_FALL_PH);
    assign w_load   = w_fall && (cnt_q[9:5] == 5'd0);

    always_comb begin
        cnt_d       = cnt_q + 11'd1;
        hold_full_d = hold_full_q;
        hold_l_d    = hold_l_q;
        hold_r_d    = hold_r_q;
        frm_l_d     = frm_l_q;
        frm_r_d     = frm_r_q;
        shift_d     = shift_q;

        if (w_xfer && hold_full_q) begin
            frm_l_d     = hold_l_q;
            frm_r_d     = hold_r_q;
            hold_full_d = 1'b0;
        end else if (w_xfer) begin
`ifdef I2S_TX_UNDERFLOW_MUTE_EN
            frm_l_d = 16'h0000;
            frm_r_d = 16'h0000;
`else
            frm_l_d = frm_l_q;
            frm_r_d = frm_r_q;
`endif
        end

        // Never overlaps a transfer that empties the holder: rdy is low then.
        if (w_accept) begin
            hold_full_d = 1'b1;
            hold_l_d    = smp_if.lft_smp;
            hold_r_d    = smp_if.rht_smp;
        end

        if (w_load) begin
            shift_d = cnt_q[10] ? {frm_r_q, 8'h00} : {frm_l_q, 8'h00};
        end else if (w_fall) begin
            shift_d = {shift_q[22:0], 1'b0};
        end

        // Registered one cycle early so the pulse lands exactly on cnt=0x7FF.
        undrflw_d = (cnt_d == C_XFER_CNT) && !hold_full_d;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q       <= 11'd0;
            hold_full_q <= 1'b0;
            hold_l_q    <= 16'h0000;
            hold_r_q    <= 16'h0000;
            frm_l_q     <= 16'h0000;
            frm_r_q     <= 16'h0000;
            shift_q     <= 24'h000000;
            undrflw_q   <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            hold_full_q <= hold_full_d;
            hold_l_q    <= hold_l_d;
            hold_r_q    <= hold_r_d;
            frm_l_q     <= frm_l_d;
            frm_r_q     <= frm_r_d;
            shift_q     <= shift_d;
            undrflw_q   <= undrflw_d;
        end
    end

    assign MCLK           = cnt_q[2];
    assign SCLK           = cnt_q[4];
    assign LRCLK          = cnt_q[10];
    assign SDin           = shift_q[23];
    assign undrflw        = undrflw_q;
    assign smp_if.smp_rdy = ~hold_full_q;

endmodule
`default_nettype wire
